// File: rtl/sh4a_decode_queue.sv
// SH4A front-end decode stage: a DEPTH-entry instruction queue filled LANES instructions at a time,
// drained one decoded instruction per cycle into a registered valid/ready output stage.
module sh4a_decode_queue #(
    parameter int LANES = 2,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 fetch_valid,
    output logic                 fetch_ready,
    input  logic [16*LANES-1:0]  fetch_data,
    input  logic [31:0]          fetch_pc,
    output logic                 dec_valid,
    input  logic                 dec_ready,
    output logic [31:0]          dec_pc,
    output logic [15:0]          dec_insn,
    output logic                 insn_valid,
    output logic                 insn_privileged,
    output logic                 src1_valid,
    output logic                 src2_valid,
    output logic                 dest_valid,
    output logic                 imm_valid,
    output logic [5:0]           src1_reg,
    output logic [5:0]           src2_reg,
    output logic [5:0]           dest_reg,
    output logic [31:0]          imm,
    output logic [5:0]           op
);
    // Operation codes and non-GPR register ids (GPR n is {2'b0, n}).
    localparam logic [5:0] OP_ILLEGAL  = 6'd0;
    localparam logic [5:0] OP_ADD      = 6'd1;
    localparam logic [5:0] OP_SUBTRACT = 6'd2;
    localparam logic [5:0] OP_MULTIPLY = 6'd3;
    localparam logic [5:0] OP_AND      = 6'd4;
    localparam logic [5:0] OP_XOR      = 6'd5;
    localparam logic [5:0] OP_STORE8   = 6'd6;
    localparam logic [5:0] OP_STORE16  = 6'd7;
    localparam logic [5:0] OP_STORE32  = 6'd8;
    localparam logic [5:0] REG_MACL    = 6'h11;
    localparam logic [5:0] REG_FPUL    = 6'h12;
    localparam logic [5:0] REG_ZERO    = 6'h3F;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [15:0]   q_insn [DEPTH];
    logic [31:0]   q_pc   [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, count_next;
    logic          push, pop;

    // Handshakes: a transfer happens on a clock edge where valid and ready are both high;
    // the output stage holds every dec_* field stable while dec_valid && !dec_ready.
    assign fetch_ready = !flush && ((CW'(DEPTH) - count) >= CW'(LANES));
    assign push        = fetch_valid && fetch_ready;
    assign pop         = (count != '0) && (!dec_valid || dec_ready);

    always_comb begin
        count_next = count;
        if (push) count_next = count_next + CW'(LANES);
        if (pop)  count_next = count_next - CW'(1);
    end

    logic [15:0] h;
    logic [5:0]  rm, rn;
    logic        d_iv, d_s1v, d_s2v, d_dv, d_immv;
    logic [5:0]  d_op, d_s1, d_s2, d_d;
    logic [31:0] d_imm;

    assign h  = q_insn[head];
    assign rm = {2'b00, h[7:4]};
    assign rn = {2'b00, h[11:8]};

    always_comb begin
        d_iv = 1'b1; d_op = OP_ILLEGAL;
        d_s1v = 1'b0; d_s1 = '0; d_s2v = 1'b0; d_s2 = '0;
        d_dv = 1'b0; d_d = '0; d_immv = 1'b0; d_imm = '0;
        casez (h)
            16'h0??7: begin d_op = OP_MULTIPLY; d_s1v = 1'b1; d_s1 = rm; d_s2v = 1'b1; d_s2 = rn; end
            16'h0009: begin
                d_op = OP_ADD; d_s1v = 1'b1; d_s1 = REG_ZERO; d_s2v = 1'b1; d_s2 = REG_ZERO;
                d_dv = 1'b1; d_d = REG_ZERO;
            end
            16'h0?1A, 16'h0?5A: begin
                d_op = OP_ADD; d_s1v = 1'b1; d_s1 = h[6] ? REG_FPUL : REG_MACL;
                d_s2v = 1'b1; d_s2 = REG_ZERO; d_dv = 1'b1; d_d = rn;
            end
            16'h4?5A: begin
                d_op = OP_ADD; d_s1v = 1'b1; d_s1 = rn; d_s2v = 1'b1; d_s2 = REG_ZERO;
                d_dv = 1'b1; d_d = REG_FPUL;
            end
            16'h2??0, 16'h2??1, 16'h2??2: begin
                d_op = (h[1:0] == 2'd0) ? OP_STORE8 : (h[1:0] == 2'd1) ? OP_STORE16 : OP_STORE32;
                d_s1v = 1'b1; d_s1 = rm; d_s2v = 1'b1; d_s2 = rn;
            end
            16'h2??9, 16'h2??A, 16'h3??8, 16'h3??C: begin
                d_op = (h[15:12] == 4'h3) ? ((h[2]) ? OP_ADD : OP_SUBTRACT)
                                          : ((h[0]) ? OP_AND : OP_XOR);
                d_s1v = 1'b1; d_s1 = rn; d_s2v = 1'b1; d_s2 = rm; d_dv = 1'b1; d_d = rn;
            end
            16'h4?10: begin
                d_op = OP_SUBTRACT; d_s1v = 1'b1; d_s1 = rn; d_immv = 1'b1; d_imm = 32'd1;
                d_dv = 1'b1; d_d = rn;
            end
            16'h6??B: begin
                d_op = OP_SUBTRACT; d_s1v = 1'b1; d_s1 = REG_ZERO; d_s2v = 1'b1; d_s2 = rm;
                d_dv = 1'b1; d_d = rn;
            end
            16'h7???, 16'hE???: begin
                d_op = OP_ADD; d_s1v = 1'b1; d_s1 = h[15] ? REG_ZERO : rn;
                d_immv = 1'b1; d_imm = {{24{h[7]}}, h[7:0]}; d_dv = 1'b1; d_d = rn;
            end
            default: d_iv = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head <= '0; tail <= '0; count <= '0;
            dec_valid <= 1'b0; dec_pc <= '0; dec_insn <= '0;
            insn_valid <= 1'b0; insn_privileged <= 1'b0;
            src1_valid <= 1'b0; src2_valid <= 1'b0; dest_valid <= 1'b0; imm_valid <= 1'b0;
            src1_reg <= '0; src2_reg <= '0; dest_reg <= '0; imm <= '0; op <= OP_ILLEGAL;
        end else begin
            if (push) begin
                for (int i = 0; i < LANES; i++) begin
                    q_insn[tail + PW'(i)] <= fetch_data[16*i +: 16];
                    q_pc[tail + PW'(i)]   <= fetch_pc + 32'(2 * i);
                end
                tail <= tail + PW'(LANES);
            end
            if (pop) begin
                head <= head + PW'(1);
                dec_valid <= 1'b1; dec_pc <= q_pc[head]; dec_insn <= h;
                insn_valid <= d_iv; insn_privileged <= 1'b0;
                src1_valid <= d_s1v; src2_valid <= d_s2v; dest_valid <= d_dv; imm_valid <= d_immv;
                src1_reg <= d_s1; src2_reg <= d_s2; dest_reg <= d_d; imm <= d_imm; op <= d_op;
            end else if (dec_ready) begin
                dec_valid <= 1'b0;
            end
            count <= count_next;
        end
    end
endmodule
